regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 39 +++
 tb/tb_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: eight WIDTH-bit registers, one written per enabled clock edge, each exposed on its own output
//   CLK       rising-edge clock for all register updates
//   RST       asynchronous active-high reset, loads RESET_VAL into every register
//   d         write data
//   load      write enable, sampled at the rising CLK edge
//   wsel      index 0..7 of the register to write
//   q0..q7    stored contents of registers 0..7, driven straight from the flops
module regfile #(
    parameter int WIDTH     = 16,
    parameter     RESET_VAL = 16'h0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic [2:0]       wsel,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
    logic [WIDTH-1:0] r [8];
    always_ff @(posedge CLK or posedge RST)
        if (RST) r <= '{default: RV};
        else if (load) r[wsel] <= d;
    assign q0 = r[0];
    assign q1 = r[1];
    assign q2 = r[2];
    assign q3 = r[3];
    assign q4 = r[4];
    assign q5 = r[5];
    assign q6 = r[6];
    assign q7 = r[7];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized self-checking bench for regfile against an eight-entry array model
module tb_regfile;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        clk_en = 1'b0;
    logic [15:0] d = '0;
    logic        load = 1'b0;
    logic [2:0]  wsel = '0;
    logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [15:0] q [8];
    logic [15:0] m [8];
    int checks = 0;
    int errors = 0;

    regfile dut (
        .CLK(CLK), .RST(RST), .d(d), .load(load), .wsel(wsel),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7)
    );

    assign q[0] = q0;
    assign q[1] = q1;
    assign q[2] = q2;
    assign q[3] = q3;
    assign q[4] = q4;
    assign q[5] = q5;
    assign q[6] = q6;
    assign q[7] = q7;

    always #5 if (clk_en) CLK = ~CLK;

    // advance one rising edge, apply the model's view of that edge, and settle away from it
    task automatic step();
        logic [15:0] sd;
        logic        sl;
        logic [2:0]  sw;
        sd = d; sl = load; sw = wsel;
        @(posedge CLK);
        if (RST) m = '{default: 16'h0000};
        else if (sl) m[sw] = sd;
        #1;
    endtask

    task automatic test_reset();
        clk_en = 1'b0;
        CLK = 1'b0;
        load = 1'b1; wsel = 3'd2; d = 16'hBEEF;
        #7 RST = 1'b1;
        #1;
        m = '{default: 16'h0000};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_no_clock q%0d got %h expected 0000", i, q[i]);
            end
        end
        load = 1'b0;
        #3 RST = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic test_write();
        load = 1'b1; wsel = 3'd3; d = 16'hA5A5;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q[i] !== (i == 3 ? 16'hA5A5 : 16'h0000)) begin
                errors++;
                $display("FAIL first_write q%0d got %h expected %h", i, q[i], i == 3 ? 16'hA5A5 : 16'h0000);
            end
        end
    endtask

    task automatic test_hold();
        load = 1'b0; wsel = 3'd3; d = 16'h1234;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (q3 !== 16'hA5A5) begin
                errors++;
                $display("FAIL hold cycle %0d q3 got %h expected a5a5", c, q3);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            load = 1'b1; wsel = 3'(n); d = 16'h1000 + 16'(n);
            step();
            for (int i = 0; i < 8; i++) begin
                logic [15:0] e;
                e = (i <= n) ? 16'h1000 + 16'(i) : (i == 3 ? 16'hA5A5 : 16'h0000);
                checks++;
                if (q[i] !== e) begin
                    errors++;
                    $display("FAIL sweep wsel=%0d q%0d got %h expected %h", n, i, q[i], e);
                end
            end
        end
        load = 1'b1; wsel = 3'd5; d = 16'h5555;
        step();
        d = 16'h6666;
        step();
        load = 1'b0;
        checks++;
        if (q5 !== 16'h6666) begin
            errors++;
            $display("FAIL last_write_wins q5 got %h expected 6666", q5);
        end
    endtask

    task automatic test_reset_priority();
        load = 1'b1; wsel = 3'd7; d = 16'hFFFF;
        RST = 1'b1;
        #1;
        m = '{default: 16'h0000};
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_priority q%0d got %h expected 0000", i, q[i]);
            end
        end
        RST = 1'b0;
        step();
        checks++;
        if (q7 !== 16'hFFFF) begin
            errors++;
            $display("FAIL write_after_reset q7 got %h expected ffff", q7);
        end
        wsel = 3'd1; d = 16'h0F0F;
        step();
        load = 1'b0;
        #2 RST = 1'b1;
        #1;
        m = '{default: 16'h0000};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q[i] !== 16'h0000) begin
                errors++;
                $display("FAIL midseq_reset q%0d got %h expected 0000", i, q[i]);
            end
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 20; c++) begin
            d = 16'($urandom); load = 1'($urandom); wsel = 3'($urandom);
            step();
            // scramble inputs between edges; only the values present at the edge matter
            d = 16'($urandom); load = 1'($urandom); wsel = 3'($urandom);
            @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q[i] !== m[i]) begin
                    errors++;
                    $display("FAIL random cycle %0d q%0d got %h expected %h", c, i, q[i], m[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
